// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit controller and its
// request legality checker.
package lsu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CAPT,
      ST_STORE,
      ST_DONE
   } lsu_state_e;

   typedef enum logic [1:0] {
      ERR_OK       = 2'b00,
      ERR_MISALIGN = 2'b01,
      ERR_FAULT    = 2'b10,
      ERR_FUNCT3   = 2'b11
   } lsu_err_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam int unsigned RD_LAT_DEF    = 2;
   localparam int unsigned MEM_BYTES_DEF = 1024;

endpackage

// File: rtl/lsu_check.sv
// Combinational legality check of a load/store request: illegal funct3 wins
// over misalignment, which wins over an out-of-range address.
module lsu_check
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_BYTES = MEM_BYTES_DEF
) (
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [2:0]  funct3,
   output logic [1:0]  err
);

   logic legal;
   logic misal;

   always_comb begin
      legal = 1'b0;
      misal = 1'b0;
      case (funct3)
         F3_LB:  legal = 1'b1;
         F3_LH:  begin legal = 1'b1; misal = addr[0];     end
         F3_LW:  begin legal = 1'b1; misal = |addr[1:0];  end
         F3_LBU: legal = ~we;
         F3_LHU: begin legal = ~we;  misal = addr[0];     end
         default: legal = 1'b0;
      endcase

      if (!legal)                       err = ERR_FUNCT3;
      else if (misal)                   err = ERR_MISALIGN;
      else if (addr >= 32'(MEM_BYTES))  err = ERR_FAULT;
      else                              err = ERR_OK;
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one request at a time, drives the data memory
// for its fixed read latency and returns a single-cycle response pulse.
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int unsigned RD_LAT    = RD_LAT_DEF,
   parameter int unsigned MEM_BYTES = MEM_BYTES_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_funct3,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic [1:0]  resp_err,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [2:0]  mem_funct3,
   input  logic [31:0] mem_rdata
);

   localparam int unsigned CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   lsu_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [2:0]    funct3_q, funct3_d;
   logic [1:0]    err_q, err_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [1:0]    chk_err;

   lsu_check #(.MEM_BYTES(MEM_BYTES)) u_check (
      .we     (req_we),
      .addr   (req_addr),
      .funct3 (req_funct3),
      .err    (chk_err)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      funct3_d = funct3_q;
      err_d    = err_q;
      rdata_d  = rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               funct3_d = req_funct3;
               err_d    = chk_err;
               cnt_d    = '0;
               if (chk_err != ERR_OK) begin
                  rdata_d = '0;
                  state_d = ST_DONE;
               end else if (req_we) begin
                  rdata_d = '0;
                  state_d = ST_STORE;
               end else begin
                  state_d = ST_LOAD;
               end
            end
         end
         // mem_read stays high for RD_LAT cycles; the counter marks the last one
         ST_LOAD: begin
            if (cnt_q == CW'(RD_LAT - 1)) state_d = ST_CAPT;
            else                          cnt_d   = cnt_q + 1'b1;
         end
         ST_CAPT: begin
            rdata_d = mem_rdata;
            state_d = ST_DONE;
         end
         ST_STORE: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         funct3_q <= '0;
         err_q    <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         funct3_q <= funct3_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end

   assign req_ready  = (state_q == ST_IDLE);
   assign resp_valid = (state_q == ST_DONE);
   assign mem_read   = (state_q == ST_LOAD);
   assign mem_write  = (state_q == ST_STORE);
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign mem_funct3 = funct3_q;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: two-edge-latency data memory, a timeline model of the
// expected outputs checked every cycle, and directed requests with literal checks.
module tb_lsu_ctrl;

   localparam int RD_LAT = 2;
   localparam int MEMB   = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [2:0]  req_funct3 = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_err;
   logic        mem_read, mem_write;
   logic [31:0] mem_addr, mem_wdata;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   lsu_ctrl #(.RD_LAT(RD_LAT), .MEM_BYTES(MEMB)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- byte memories (device and reference) ----------------
   logic [7:0] env_mem [MEMB];
   logic [7:0] ref_mem [MEMB];

   function automatic logic [31:0] extend(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input logic [7:0] b3,
                                          input logic [2:0] f);
      case (f)
         3'b000:  return {{24{b0[7]}}, b0};
         3'b001:  return {{16{b1[7]}}, b1, b0};
         3'b010:  return {b3, b2, b1, b0};
         3'b100:  return {24'h0, b0};
         3'b101:  return {16'h0, b1, b0};
         default: return 32'h0;
      endcase
   endfunction

   logic [31:0] m_a_q = '0;
   logic [2:0]  m_f_q = '0;
   logic [31:0] m_rd_q = '0;
   assign mem_rdata = m_rd_q;

   always @(posedge clk) begin
      if (rst) begin
         m_a_q  <= '0;
         m_f_q  <= '0;
         m_rd_q <= '0;
      end else begin
         if (mem_write && mem_addr < MEMB) begin
            env_mem[mem_addr[9:0]] <= mem_wdata[7:0];
            if (mem_funct3[1:0] != 2'b00) env_mem[mem_addr[9:0] + 10'd1] <= mem_wdata[15:8];
            if (mem_funct3[1:0] == 2'b10) begin
               env_mem[mem_addr[9:0] + 10'd2] <= mem_wdata[23:16];
               env_mem[mem_addr[9:0] + 10'd3] <= mem_wdata[31:24];
            end
         end
         if (mem_read) begin
            m_a_q <= mem_addr;
            m_f_q <= mem_funct3;
         end
         m_rd_q <= extend(env_mem[m_a_q[9:0]], env_mem[m_a_q[9:0] + 10'd1],
                          env_mem[m_a_q[9:0] + 10'd2], env_mem[m_a_q[9:0] + 10'd3], m_f_q);
      end
   end

   // ---------------- timeline model ----------------
   function automatic logic [1:0] ref_err(input logic we, input logic [31:0] a, input logic [2:0] f);
      bit legal;
      int size;
      legal = we ? (f <= 3'd2) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      size  = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
      if (!legal)        return 2'b11;
      if (a % size != 0) return 2'b01;
      if (a >= MEMB)     return 2'b10;
      return 2'b00;
   endfunction

   bit          model_ok = 0;
   bit          active = 0;
   int          k = 0;
   int          lat = 0;
   bit          ok_load = 0, ok_store = 0;
   logic [31:0] ldval = '0;
   logic        exp_ready = 1'b1, exp_rv = 1'b0, exp_mr = 1'b0, exp_mw = 1'b0;
   logic [31:0] exp_rdata = '0, exp_addr = '0, exp_wdata = '0;
   logic [2:0]  exp_f3 = '0;
   logic [1:0]  exp_err = '0;

   always @(posedge clk) begin
      logic [1:0] e;
      logic [9:0] a;
      if (rst) begin
         model_ok = 1; active = 0; k = 0;
         exp_ready = 1'b1; exp_rv = 1'b0; exp_mr = 1'b0; exp_mw = 1'b0;
         exp_rdata = '0; exp_addr = '0; exp_wdata = '0; exp_f3 = '0; exp_err = '0;
      end else if (model_ok) begin
         if (req_valid && exp_ready) begin
            e = ref_err(req_we, req_addr, req_funct3);
            a = req_addr[9:0];
            exp_err = e; exp_addr = req_addr; exp_wdata = req_wdata; exp_f3 = req_funct3;
            ok_load  = (e == 2'b00) && !req_we;
            ok_store = (e == 2'b00) && req_we;
            lat = (e != 2'b00) ? 1 : req_we ? 2 : RD_LAT + 2;
            if (!ok_load) exp_rdata = '0;
            if (ok_store) begin
               ref_mem[a] = req_wdata[7:0];
               if (req_funct3 != 3'b000) ref_mem[a + 10'd1] = req_wdata[15:8];
               if (req_funct3 == 3'b010) begin
                  ref_mem[a + 10'd2] = req_wdata[23:16];
                  ref_mem[a + 10'd3] = req_wdata[31:24];
               end
            end
            if (ok_load)
               ldval = extend(ref_mem[a], ref_mem[a + 10'd1], ref_mem[a + 10'd2],
                              ref_mem[a + 10'd3], req_funct3);
            active = 1; k = 1;
         end else if (active) begin
            k++;
         end
         if (active && k > lat) active = 0;
         exp_ready = !active;
         exp_mr = active && ok_load && k <= RD_LAT;
         exp_mw = active && ok_store && k == 1;
         exp_rv = active && k == lat;
         if (active && ok_load && k == RD_LAT + 2) exp_rdata = ldval;
      end
   end

   always @(negedge clk) begin
      if (model_ok) begin
         chk("req_ready",  32'(req_ready),  32'(exp_ready));
         chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
         chk("resp_rdata", resp_rdata,      exp_rdata);
         chk("resp_err",   32'(resp_err),   32'(exp_err));
         chk("mem_read",   32'(mem_read),   32'(exp_mr));
         chk("mem_write",  32'(mem_write),  32'(exp_mw));
         chk("mem_addr",   mem_addr,        exp_addr);
         chk("mem_wdata",  mem_wdata,       exp_wdata);
         chk("mem_funct3", 32'(mem_funct3), 32'(exp_f3));
         chk("rw_excl",    32'(mem_read & mem_write), 32'd0);
      end
   end

   // ---------------- directed stimulus ----------------
   int          r_lat;
   logic [31:0] r_rd;
   logic [1:0]  r_err;
   logic [31:0] r_rmask, r_wmask;

   task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3);
      bit acc;
      acc = 0;
      r_lat = 0; r_rd = 'x; r_err = 'x; r_rmask = '0; r_wmask = '0;
      @(posedge clk); #2;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
      for (int i = 0; i < 40 && !acc; i++) begin
         @(negedge clk);
         if (req_ready) acc = 1;
         @(posedge clk);
      end
      #2 req_valid = 1'b0;
      if (!acc) begin
         chk("accept_timeout", 32'd0, 32'd1);
         return;
      end
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (mem_read)  r_rmask[n] = 1'b1;
         if (mem_write) r_wmask[n] = 1'b1;
         if (resp_valid) begin
            r_lat = n; r_rd = resp_rdata; r_err = resp_err;
            break;
         end
         @(posedge clk);
      end
   endtask

   initial begin
      for (int i = 0; i < MEMB; i++) begin
         env_mem[i] = 8'(i * 7 + 3);
         ref_mem[i] = 8'(i * 7 + 3);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1);
   end

   initial begin
      logic [31:0] rv_mask, rdy_mask, q_rd;
      int          resp_cnt;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_rv",    32'(resp_valid), 32'd0);
      chk("rst_mr",    32'(mem_read | mem_write), 32'd0);
      chk("rst_addr",  mem_addr, 32'd0);
      @(posedge clk); #2 rst = 1'b0;

      do_req(1'b1, 32'h10, 32'hDEADBEEF, 3'b010);
      chk("sw_lat", 32'(r_lat), 32'd2);
      chk("sw_wmask", r_wmask, 32'h2);
      chk("sw_rmask", r_rmask, 32'h0);
      chk("sw_err", 32'(r_err), 32'd0);

      do_req(1'b0, 32'h10, 32'h0, 3'b010);
      chk("lw_lat", 32'(r_lat), 32'd4);
      chk("lw_rmask", r_rmask, 32'h6);
      chk("lw_wmask", r_wmask, 32'h0);
      chk("lw_data", r_rd, 32'hDEADBEEF);
      chk("lw_err", 32'(r_err), 32'd0);

      do_req(1'b1, 32'h21, 32'h00000080, 3'b000);
      chk("sb_lat", 32'(r_lat), 32'd2);
      do_req(1'b0, 32'h21, 32'h0, 3'b000);
      chk("lb_data", r_rd, 32'hFFFFFF80);
      do_req(1'b0, 32'h21, 32'h0, 3'b100);
      chk("lbu_data", r_rd, 32'h00000080);

      do_req(1'b0, 32'h22, 32'h0, 3'b010);
      chk("lw_mis_lat", 32'(r_lat), 32'd1);
      chk("lw_mis_err", 32'(r_err), 32'd1);
      chk("lw_mis_rd", r_rd, 32'd0);
      chk("lw_mis_mem", r_rmask | r_wmask, 32'd0);

      do_req(1'b1, 32'h400, 32'h12345678, 3'b010);
      chk("sw_flt_lat", 32'(r_lat), 32'd1);
      chk("sw_flt_err", 32'(r_err), 32'd2);
      chk("sw_flt_rd", r_rd, 32'd0);
      chk("sw_flt_mem", r_rmask | r_wmask, 32'd0);

      do_req(1'b0, 32'h10, 32'h0, 3'b011);
      chk("f3_lat", 32'(r_lat), 32'd1);
      chk("f3_err", 32'(r_err), 32'd3);
      chk("f3_rd", r_rd, 32'd0);
      chk("f3_mem", r_rmask | r_wmask, 32'd0);

      do_req(1'b1, 32'h31, 32'h00001234, 3'b001);
      chk("sh_mis_err", 32'(r_err), 32'd1);
      chk("sh_mis_mem", r_rmask | r_wmask, 32'd0);
      do_req(1'b0, 32'h30, 32'h0, 3'b101);
      chk("lhu_prior", r_rd, 32'h00005A53);

      // reset during cycle 2 of a load
      @(posedge clk); #2;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010;
      @(posedge clk); #2 req_valid = 1'b0;
      @(posedge clk); #2 rst = 1'b1;
      @(posedge clk); #2 rst = 1'b0;
      @(negedge clk);
      chk("rstmid_ready", 32'(req_ready), 32'd1);
      chk("rstmid_rd",    resp_rdata, 32'd0);
      chk("rstmid_mr",    32'(mem_read), 32'd0);
      chk("rstmid_addr",  mem_addr, 32'd0);
      resp_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (resp_valid) resp_cnt++;
      end
      chk("rstmid_noresp", 32'(resp_cnt), 32'd0);

      // reset together with a valid request
      @(posedge clk); #2;
      rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010;
      @(posedge clk); #2 rst = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      chk("rstreq_ready", 32'(req_ready), 32'd1);
      chk("rstreq_mr",    32'(mem_read), 32'd0);

      // two loads back to back with req_valid held high
      rv_mask = '0; rdy_mask = '0; q_rd = '0;
      @(posedge clk); #2;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010;
      @(posedge clk); #2;
      req_addr = 32'h21; req_funct3 = 3'b100;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         if (req_ready)  rdy_mask[n] = 1'b1;
         if (resp_valid) begin rv_mask[n] = 1'b1; q_rd = resp_rdata; end
         @(posedge clk); #2;
         if (rdy_mask[n]) req_valid = 1'b0;
      end
      chk("q_ready_mask", rdy_mask, 32'h00001C20);
      chk("q_resp_mask",  rv_mask,  32'h00000210);
      chk("q_second_rd",  q_rd,     32'h00000080);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit controller between the core's execute stage and the byte-addressable data memory. It accepts one load or store request at a time over a valid/ready handshake and checks funct3 legality, alignment and address range. It then drives the memory's MemRead/MemWrite/addr/write_data/funct3 pins for the memory's fixed two-edge read latency, captures the memory's already sign/zero-extended read data, and returns a single-cycle response pulse to the core.

## Interface
- RD_LAT, 2, clock edges from first mem_read cycle to valid mem_rdata (address-register edge plus data-register edge)
- MEM_BYTES, 1024, memory size in bytes; multiple of 4
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  core request valid
- req_ready  out  1  controller can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low bytes used per funct3
- req_funct3  in  3  RV32I load/store funct3
- resp_valid  out  1  one-cycle response pulse; no back-pressure
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  2  00 ok, 01 misaligned, 10 access fault, 11 illegal funct3
- mem_read  out  1  to memory MemRead
- mem_write  out  1  to memory MemWrite
- mem_addr  out  32  to memory addr
- mem_wdata  out  32  to memory write_data
- mem_funct3  out  3  to memory funct3
- mem_rdata  in  32  from memory read_data

## Operation
- Request accepted at a clock edge where req_valid && req_ready. All request fields are registered at that edge. mem_addr, mem_wdata and mem_funct3 are driven from these registers and hold until the next accept.
- Check priority, evaluated on the inputs at accept:
  - illegal funct3 (11): loads must be 000/001/010/100/101; stores must be 000/001/010
  - misaligned (01): halfword with addr[0]=1, word with addr[1:0]≠0
  - access fault (10): addr ≥ MEM_BYTES
- FSM states IDLE, LOAD, CAPT, STORE, DONE:
  - IDLE: on accept, go to DONE if any error, else STORE if req_we, else LOAD.
  - LOAD: mem_read=1 for exactly RD_LAT cycles (counter), address and funct3 held stable, then CAPT.
  - CAPT: mem_read=0. resp_rdata <= mem_rdata at the end of the cycle, then DONE.
  - STORE: mem_write=1 for exactly one cycle, then DONE.
  - DONE: resp_valid=1 for one cycle, then IDLE.
- Errored requests never assert mem_read or mem_write.
- resp_rdata is cleared to 0 when a store or error request is accepted.
- resp_err is registered at accept and held until the next accept.
- Requests presented while req_ready=0 are ignored; the core must hold them.

## Timing
- Cycle 0 is the accept cycle.
- Load: mem_read high in cycles 1..RD_LAT, CAPT in cycle RD_LAT+1, resp_valid in cycle RD_LAT+2 (cycle 4 at default).
- Store: mem_write high in cycle 1, resp_valid in cycle 2.
- Error: resp_valid in cycle 1.
- req_ready returns high in the cycle after DONE. Back-to-back throughput: loads every RD_LAT+3 cycles, stores every 3.
- mem_read and mem_write are never high in the same cycle.
- Reset values:
  - state IDLE, req_ready=1
  - resp_valid=0, resp_rdata=0, resp_err=00
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, mem_funct3=000
- rst mid-operation: the next cycle is IDLE with all outputs at reset values, and no response is issued for the in-flight request. The memory is reset by the same rst.
- rst together with req_valid: the request is not accepted.

## Structure
- lsu_pkg:
  - state enum
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW)
  - resp_err codes
  - RD_LAT default
- One combinational sub-module, lsu_check: inputs we, addr, funct3; outputs the 2-bit error code. Reused later by the pipelined core.

## Test plan
- SW 0xDEADBEEF to 0x10, then LW 0x10:
  - mem_write high only in cycle 1
  - for the load, mem_read high only in cycles 1–2
  - resp_valid in cycle 4 with resp_rdata=0xDEADBEEF, resp_err=00
- SB 0x00000080 at 0x21, then LB 0x21, then LBU 0x21 → resp_rdata 0xFFFFFF80, then 0x00000080.
- Three error requests, each giving resp_valid in cycle 1, resp_rdata=0 and mem_read/mem_write never asserted:
  - LW at 0x22 → resp_err=01
  - SW at 0x400 → resp_err=10
  - load with funct3=011 → resp_err=11
- SH 0x1234 at 0x31 (misaligned and in range) → resp_err=01 and memory unchanged; a following LHU 0x30 returns its prior contents.
- rst asserted in cycle 2 of a load → next cycle req_ready=1 and all outputs at reset values; no resp_valid is ever seen for that load.
- req_valid held high with two queued loads → req_ready low from cycle 1 through 4; the second accept happens in cycle 5 and its resp_valid appears in cycle 9.
